// File: rtl/lc3_mem_responder_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Device register addresses in the xFExx MMIO page
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [7:0]  MMIO_PAGE = 8'hFE;

    // Wait counter width; holds WAIT_CYCLES up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/lc3_mem_responder_if.sv
// CPU <-> memory MAR/MDR request/response bus.
interface lc3_mem_if;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy;
    logic        mem_err;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_rdy, mem_err
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_rdy, mem_err
    );
endinterface

// File: rtl/lc3_mem_responder_mmio.sv
// Keyboard/display device registers and xFExx page decode.
// Only instantiated when LC3_MEM_MMIO_EN is defined.
module lc3_mem_mmio
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_we,
    input  logic [15:0] i_wdata,
    input  logic        i_commit,
    input  logic        i_kbd_valid,
    input  logic [7:0]  i_kbd_data,
    input  logic        i_disp_ready,
    output logic        o_hit,
    output logic [15:0] o_rdata,
    output logic        o_disp_valid,
    output logic [7:0]  o_disp_data
);
    logic       r_kbsr;
    logic [7:0] r_kbdr;
    logic       r_disp_valid;
    logic [7:0] r_disp_data;
    logic       w_unused_wdata;

    assign w_unused_wdata = ^i_wdata[15:8];
    assign o_hit          = (i_addr[15:8] == MMIO_PAGE);

    // Read mux for the device page; unmapped page addresses read 0
    always_comb begin
        o_rdata = 16'h0000;
        unique case (i_addr)
            KBSR_ADDR: o_rdata = {r_kbsr, 15'b0};
            KBDR_ADDR: o_rdata = {8'h00, r_kbdr};
            DSR_ADDR:  o_rdata = {i_disp_ready, 15'b0};
            default:   o_rdata = 16'h0000;
        endcase
    end

    // Keyboard regs: a new character beats a same-edge KBDR read clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kbsr <= 1'b0;
            r_kbdr <= 8'h00;
        end else if (i_kbd_valid) begin
            r_kbsr <= 1'b1;
            r_kbdr <= i_kbd_data;
        end else if (i_commit && !i_we && i_addr == KBDR_ADDR) begin
            r_kbsr <= 1'b0;
        end
    end

    // Display write strobe: one cycle, aligned with the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_valid <= 1'b0;
            r_disp_data  <= 8'h00;
        end else begin
            r_disp_valid <= 1'b0;
            if (i_commit && i_we && i_addr == DDR_ADDR) begin
                r_disp_valid <= 1'b1;
                r_disp_data  <= i_wdata[7:0];
            end
        end
    end

    assign o_disp_valid = r_disp_valid;
    assign o_disp_data  = r_disp_data;
endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: latches one request, waits WAIT_CYCLES, then
// commits the write or returns read data with a one-cycle mem_rdy.
// Optional MMIO device page enabled by defining LC3_MEM_MMIO_EN.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int DEPTH       = 65536,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    lc3_mem_if.slave    bus,
    input  logic        i_kbd_valid,
    input  logic [7:0]  i_kbd_data,
    input  logic        i_disp_ready,
    output logic        o_disp_valid,
    output logic [7:0]  o_disp_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]      r_mem [DEPTH];
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_addr, r_wdata, r_rdata;
    logic             r_we, r_rdy, r_err;
    logic             w_accept, w_commit, w_in_range, w_hit;
    logic [15:0]      w_mmio_rdata, w_rd_val;

    assign w_in_range = ({1'b0, r_addr} < 17'(DEPTH));
    assign w_rd_val   = w_hit      ? w_mmio_rdata :
                        w_in_range ? r_mem[r_addr[AW-1:0]] : 16'h0000;

`ifdef LC3_MEM_MMIO_EN
    lc3_mem_mmio u_mmio (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (r_addr),
        .i_we         (r_we),
        .i_wdata      (r_wdata),
        .i_commit     (w_commit),
        .i_kbd_valid  (i_kbd_valid),
        .i_kbd_data   (i_kbd_data),
        .i_disp_ready (i_disp_ready),
        .o_hit        (w_hit),
        .o_rdata      (w_mmio_rdata),
        .o_disp_valid (o_disp_valid),
        .o_disp_data  (o_disp_data)
    );
`else
    logic w_unused_mmio;
    assign w_unused_mmio = ^{i_kbd_valid, i_kbd_data, i_disp_ready};
    assign w_hit         = 1'b0;
    assign w_mmio_rdata  = 16'h0000;
    assign o_disp_valid  = 1'b0;
    assign o_disp_data   = 8'h00;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state; accept in IDLE, commit when the wait counter runs out
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            IDLE: if (bus.mem_en) begin
                w_accept    = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: if (r_cnt == '0) begin
                w_commit    = 1'b1;
                w_state_nxt = RESP;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch, wait counter and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_addr  <= 16'h0000;
            r_we    <= 1'b0;
            r_wdata <= 16'h0000;
            r_rdata <= 16'h0000;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 16'h0000;
            if (w_accept) begin
                r_addr  <= bus.mem_addr;
                r_we    <= bus.mem_we;
                r_wdata <= bus.mem_wdata;
                r_cnt   <= CNT_W'(WAIT_CYCLES);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_rdy   <= 1'b1;
                r_err   <= !w_hit && !w_in_range;
                r_rdata <= r_we ? 16'h0000 : w_rd_val;
            end
        end
    end

    // RAM write port; a reset landing on the commit edge drops the write
    always_ff @(posedge clk) begin
        if (w_commit && r_we && w_in_range && !w_hit && !rst)
            r_mem[r_addr[AW-1:0]] <= r_wdata;
    end

    assign bus.mem_rdata = r_rdata;
    assign bus.mem_rdy   = r_rdy;
    assign bus.mem_err   = r_err;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: timing/value reference model plus directed
// literal checks and randomized transactions. Honours LC3_MEM_MMIO_EN.
module tb_lc3_mem_responder;
    localparam int DA = 16384;
    localparam int WA = 2;
    localparam int WB = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbd_valid = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       disp_ready = 1'b0;
    logic       disp_valid_a, disp_valid_b;
    logic [7:0] disp_data_a, disp_data_b;

    int n_cmp = 0;
    int n_bad = 0;

    lc3_mem_if bus_a ();
    lc3_mem_if bus_b ();

    lc3_mem_responder #(.DEPTH(DA), .WAIT_CYCLES(WA)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .i_kbd_valid(kbd_valid), .i_kbd_data(kbd_data), .i_disp_ready(disp_ready),
        .o_disp_valid(disp_valid_a), .o_disp_data(disp_data_a)
    );

    lc3_mem_responder #(.DEPTH(DA), .WAIT_CYCLES(WB)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .i_kbd_valid(1'b0), .i_kbd_data(8'h00), .i_disp_ready(1'b0),
        .o_disp_valid(disp_valid_b), .o_disp_data(disp_data_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (DUT A) ----------------
    // Timing rule: request seen at edge n answers at edge n+WA+1 and the
    // next request may be accepted at edge n+WA+3.
    int          n_edge = 0;
    bit          p_vld = 0;
    bit          p_we;
    logic [15:0] p_addr, p_wdata;
    int          p_edge, free_edge = 0;
    logic [15:0] mm [int];
    logic        exp_rdy = 0, exp_err = 0, exp_dv = 0;
    logic [15:0] exp_rdata = 0;
    logic [7:0]  exp_dd = 0;
    bit          exp_known = 1;
    bit          m_kbsr = 0;
    logic [7:0]  m_kbdr = 0;

    always @(posedge clk) begin
        n_edge++;
        if (rst) begin
            p_vld = 0; free_edge = n_edge + 1;
            exp_rdy = 0; exp_err = 0; exp_rdata = 0; exp_known = 1;
            exp_dv = 0; exp_dd = 0; m_kbsr = 0; m_kbdr = 0;
        end else begin
            exp_rdy = 0; exp_err = 0; exp_rdata = 0; exp_known = 1; exp_dv = 0;
            if (p_vld && n_edge == p_edge) begin
                bit dev, inr;
                p_vld   = 0;
                exp_rdy = 1;
                inr     = (int'(p_addr) < DA);
`ifdef LC3_MEM_MMIO_EN
                dev = (p_addr[15:8] == 8'hFE);
`else
                dev = 0;
`endif
                if (dev) begin
                    exp_known = !p_we;
                    if (p_we) begin
                        if (p_addr == 16'hFE06) begin exp_dv = 1; exp_dd = p_wdata[7:0]; end
                    end else begin
                        case (p_addr)
                            16'hFE00: exp_rdata = m_kbsr ? 16'h8000 : 16'h0000;
                            16'hFE02: begin exp_rdata = {8'h00, m_kbdr}; m_kbsr = 0; end
                            16'hFE04: exp_rdata = disp_ready ? 16'h8000 : 16'h0000;
                            default:  exp_rdata = 16'h0000;
                        endcase
                    end
                end else if (p_we) begin
                    if (inr) mm[int'(p_addr)] = p_wdata;
                    exp_err = !inr; exp_known = 0;
                end else begin
                    exp_err = !inr;
                    if (inr) begin
                        if (mm.exists(int'(p_addr))) exp_rdata = mm[int'(p_addr)];
                        else exp_known = 0;
                    end
                end
            end
`ifdef LC3_MEM_MMIO_EN
            if (kbd_valid) begin m_kbsr = 1; m_kbdr = kbd_data; end
`endif
            if (!p_vld && n_edge >= free_edge && bus_a.mem_en) begin
                p_vld = 1; p_we = bus_a.mem_we; p_addr = bus_a.mem_addr;
                p_wdata = bus_a.mem_wdata;
                p_edge = n_edge + WA + 1; free_edge = n_edge + WA + 3;
            end
        end
    end

    // Per-cycle compare of DUT A against the model
    always @(negedge clk) begin
        chk("rdy", 32'(bus_a.mem_rdy), 32'(exp_rdy));
        chk("err", 32'(bus_a.mem_err), 32'(exp_err));
        if (exp_known) chk("rdata", 32'(bus_a.mem_rdata), 32'(exp_rdata));
        chk("disp_valid", 32'(disp_valid_a), 32'(exp_dv));
        chk("disp_data", 32'(disp_data_a), 32'(exp_dd));
    end

    // ---------------- driver ----------------
    task automatic xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input bit scramble, output logic [15:0] rd, output logic err,
                        output int lat, output logic dv, output logic [7:0] dd);
        bit got = 0;
        rd = 'x; err = 'x; dv = 'x; dd = 'x; lat = 0;
        @(negedge clk); #1;
        bus_a.mem_en = 1; bus_a.mem_we = we; bus_a.mem_addr = addr; bus_a.mem_wdata = wdata;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus_a.mem_rdy) begin
                got = 1; rd = bus_a.mem_rdata; err = bus_a.mem_err;
                dv = disp_valid_a; dd = disp_data_a;
            end else if (scramble) begin
                #1; bus_a.mem_addr = 16'($urandom); bus_a.mem_wdata = 16'($urandom);
                bus_a.mem_we = 1'($urandom);
            end
        end
        #1 bus_a.mem_en = 0;
        if (!got) chk("xact_timeout", 32'(got), 32'd1);
    endtask

    logic [15:0] rd;
    logic        er, dv;
    logic [7:0]  dd;
    int          lat;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus_a.mem_en = 0; bus_a.mem_we = 0; bus_a.mem_addr = 0; bus_a.mem_wdata = 0;
        bus_b.mem_en = 0; bus_b.mem_we = 0; bus_b.mem_addr = 0; bus_b.mem_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(bus_a.mem_rdy), 0);
        chk("rst_err", 32'(bus_a.mem_err), 0);
        chk("rst_rdata", 32'(bus_a.mem_rdata), 0);
        chk("rst_dv", 32'(disp_valid_a), 0);
        chk("rst_dd", 32'(disp_data_a), 0);
        #1 rst = 0;

        // Write then read x3000 with 2 wait states
        xact(1, 16'h3000, 16'h1234, 0, rd, er, lat, dv, dd);
        chk("wr_lat", 32'(lat), 32'd4);
        chk("wr_err", 32'(er), 0);
        xact(0, 16'h3000, 16'h0, 0, rd, er, lat, dv, dd);
        chk("rd_lat", 32'(lat), 32'd4);
        chk("rd_data", 32'(rd), 32'h1234);

        // Reset while a write of xBEEF is pending
        begin
            int pulses = 0;
            @(negedge clk); #1;
            bus_a.mem_en = 1; bus_a.mem_we = 1; bus_a.mem_addr = 16'h3000; bus_a.mem_wdata = 16'hBEEF;
            @(negedge clk); #1;
            rst = 1; bus_a.mem_en = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus_a.mem_rdy) pulses++;
                if (i == 1) #1 rst = 0;
            end
            chk("rst_mid_no_rdy", 32'(pulses), 0);
        end
        xact(0, 16'h3000, 16'h0, 0, rd, er, lat, dv, dd);
        chk("rst_mid_keep", 32'(rd), 32'h1234);

        // Inputs changing during WAIT are ignored
        xact(1, 16'h3001, 16'h5555, 1, rd, er, lat, dv, dd);
        xact(0, 16'h3001, 16'h0, 0, rd, er, lat, dv, dd);
        chk("latch_data", 32'(rd), 32'h5555);

        // Depth boundary and out-of-range
        xact(1, 16'h5000, 16'hAAAA, 0, rd, er, lat, dv, dd);
        chk("oor_wr_err", 32'(er), 1);
        xact(0, 16'h5000, 16'h0, 0, rd, er, lat, dv, dd);
        chk("oor_rd_err", 32'(er), 1);
        chk("oor_rd_data", 32'(rd), 0);
        xact(1, 16'h3FFF, 16'hC0DE, 0, rd, er, lat, dv, dd);
        chk("top_wr_err", 32'(er), 0);
        xact(0, 16'h3FFF, 16'h0, 0, rd, er, lat, dv, dd);
        chk("top_rd_data", 32'(rd), 32'hC0DE);
        xact(0, 16'h4000, 16'h0, 0, rd, er, lat, dv, dd);
        chk("edge_rd_err", 32'(er), 1);

`ifdef LC3_MEM_MMIO_EN
        @(negedge clk); #1 kbd_valid = 1; kbd_data = 8'h41;
        @(negedge clk); #1 kbd_valid = 0;
        xact(0, 16'hFE00, 16'h0, 0, rd, er, lat, dv, dd);
        chk("kbsr_set", 32'(rd), 32'h8000);
        chk("kbsr_err", 32'(er), 0);
        xact(0, 16'hFE02, 16'h0, 0, rd, er, lat, dv, dd);
        chk("kbdr", 32'(rd), 32'h0041);
        xact(0, 16'hFE00, 16'h0, 0, rd, er, lat, dv, dd);
        chk("kbsr_clr", 32'(rd), 32'h0000);
        xact(1, 16'hFE06, 16'h0048, 0, rd, er, lat, dv, dd);
        chk("ddr_dv", 32'(dv), 1);
        chk("ddr_dd", 32'(dd), 32'h48);
        disp_ready = 1;
        xact(0, 16'hFE04, 16'h0, 0, rd, er, lat, dv, dd);
        chk("dsr", 32'(rd), 32'h8000);
        disp_ready = 0;
`endif

        // Zero wait states, mem_en held: one response every 3 cycles
        begin
            int pulses = 0, first = 0, last = 0;
            @(negedge clk); #1;
            bus_b.mem_en = 1; bus_b.mem_we = 0; bus_b.mem_addr = 16'h0010;
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                if (bus_b.mem_rdy) begin
                    pulses++;
                    if (first == 0) first = i;
                    last = i;
                end
            end
            #1 bus_b.mem_en = 0;
            chk("b2b_pulses", 32'(pulses), 32'd4);
            chk("b2b_first", 32'(first), 32'd2);
            chk("b2b_last", 32'(last), 32'd11);
        end

        // Randomized traffic, checked cycle by cycle by the model
        for (int t = 0; t < 300; t++) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0: a = 16'h3000 + 16'($urandom_range(0, 7));
                1: a = 16'($urandom_range(0, DA - 1));
                2: a = 16'($urandom_range(DA - 4, DA + 4));
                default: a = 16'($urandom);
            endcase
`ifdef LC3_MEM_MMIO_EN
            if (a[15:8] == 8'hFE) a = a ^ 16'h0100;
`endif
            xact(1'($urandom), a, 16'($urandom), bit'($urandom_range(0, 1)), rd, er, lat, dv, dd);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
